// File: rtl/wb_dsp_slave_regfile.sv
// Wishbone classic slave register file for the DSP block.
// Provides byte-writable control registers, read-only status words, a latched
// and maskable interrupt controller with write-1-to-clear pending bits, and
// error responses for unmapped indices or writes to status words.
module wb_dsp_slave_regfile #(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int NUM_CTRL = 4,
  parameter int NUM_STAT = 2,
  parameter int NUM_IRQ  = 8
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic [AW-1:0]            wb_adr_i,
  input  logic [DW-1:0]            wb_dat_i,
  input  logic [DW/8-1:0]          wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [DW-1:0]            wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic [NUM_CTRL*DW-1:0]   ctrl_regs_o,
  input  logic [NUM_STAT*DW-1:0]   status_regs_i,
  input  logic [NUM_IRQ-1:0]       irq_src_i,
  output logic                     interrupt
);

  localparam int IW = AW - 2;
  localparam int SW = DW / 8;
  localparam logic [IW-1:0] STAT_IDX = IW'(NUM_CTRL);
  localparam logic [IW-1:0] PEND_IDX = IW'(NUM_CTRL + NUM_STAT);
  localparam logic [IW-1:0] EN_IDX   = IW'(NUM_CTRL + NUM_STAT + 1);

  logic [IW-1:0]      idx;
  logic               req;
  logic               is_ctrl;
  logic               is_stat;
  logic               is_pend;
  logic               is_en;
  logic               bad;
  logic               do_wr;
  logic               do_rd;
  logic [DW-1:0]      sel_mask;
  logic [DW-1:0]      rdata;
  logic [DW-1:0]      ctrl_reg [NUM_CTRL];
  logic [NUM_IRQ-1:0] pend_reg;
  logic [NUM_IRQ-1:0] pend_next;
  logic [NUM_IRQ-1:0] en_reg;
  logic [NUM_IRQ-1:0] irq_prev_reg;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               unused_bits;

  // Classic cycles only; burst tags and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};
  assign wb_rty_o    = 1'b0;

  // Word decode. The ack/err terms in req force an idle cycle between responses.
  assign idx     = wb_adr_i[AW-1:2];
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign is_ctrl = (idx < STAT_IDX);
  assign is_stat = (idx >= STAT_IDX) && (idx < PEND_IDX);
  assign is_pend = (idx == PEND_IDX);
  assign is_en   = (idx == EN_IDX);
  assign bad     = ~(is_ctrl | is_stat | is_pend | is_en) | (wb_we_i & is_stat);
  assign do_wr   = req & ~bad & wb_we_i;
  assign do_rd   = req & ~bad & ~wb_we_i;

  // Expand byte enables into a bit mask for byte-merged writes.
  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_sel
      assign sel_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
      assign ctrl_regs_o[gi*DW +: DW] = ctrl_reg[gi];
    end
  endgenerate

  // Read mux over every mapped word; unmapped indices never reach wb_dat_o.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (idx == IW'(i)) rdata = ctrl_reg[i];
    end
    for (int i = 0; i < NUM_STAT; i++) begin
      if (idx == IW'(NUM_CTRL + i)) rdata = status_regs_i[i*DW +: DW];
    end
    if (is_pend) rdata[NUM_IRQ-1:0] = pend_reg;
    if (is_en)   rdata[NUM_IRQ-1:0] = en_reg;
  end

  // Pending update: a fresh source rise beats a simultaneous write-1-to-clear.
  always_comb begin
    rise     = irq_src_i & ~irq_prev_reg;
    clr_mask = '0;
    if (do_wr && is_pend) clr_mask = wb_dat_i[NUM_IRQ-1:0] & sel_mask[NUM_IRQ-1:0];
    pend_next = (pend_reg & ~clr_mask) | rise;
  end

  // Bus response: one ack or err pulse per request, read data captured on ack.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & ~bad;
      wb_err_o <= req & bad;
      if (do_rd) wb_dat_o <= rdata;
    end
  end

  // Control registers, byte-merged on an acked write.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < NUM_CTRL; i++) ctrl_reg[i] <= '0;
    end else if (do_wr && is_ctrl) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (idx == IW'(i)) ctrl_reg[i] <= (ctrl_reg[i] & ~sel_mask) | (wb_dat_i & sel_mask);
      end
    end
  end

  // Interrupt state: edge history, pending, enable and the registered request.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      irq_prev_reg <= '0;
      pend_reg     <= '0;
      en_reg       <= '0;
      interrupt    <= 1'b0;
    end else begin
      irq_prev_reg <= irq_src_i;
      pend_reg     <= pend_next;
      if (do_wr && is_en) begin
        en_reg <= (en_reg & ~sel_mask[NUM_IRQ-1:0]) | (wb_dat_i[NUM_IRQ-1:0] & sel_mask[NUM_IRQ-1:0]);
      end
      interrupt <= |(pend_reg & en_reg);
    end
  end

endmodule

// File: tb/tb_wb_dsp_slave_regfile.sv
// Directed testbench for wb_dsp_slave_regfile with default parameters.
module tb_wb_dsp_slave_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   adr;
  logic [31:0]  dat_w;
  logic [3:0]   sel;
  logic         we;
  logic         cyc;
  logic         stb;
  logic [2:0]   cti;
  logic [1:0]   bte;
  logic [31:0]  dat_r;
  logic         ack;
  logic         err;
  logic         rty;
  logic [127:0] ctrl_regs;
  logic [63:0]  status_regs;
  logic [7:0]   irq_src;
  logic         irq;

  int checks = 0;
  int errors = 0;

  logic         g_ack;
  logic         g_err;
  logic [31:0]  g_dat;
  logic         g_irq;
  logic [31:0]  exp_rd [8];

  wb_dsp_slave_regfile dut (
    .wb_clk        (clk),
    .wb_rst        (rst),
    .wb_adr_i      (adr),
    .wb_dat_i      (dat_w),
    .wb_sel_i      (sel),
    .wb_we_i       (we),
    .wb_cyc_i      (cyc),
    .wb_stb_i      (stb),
    .wb_cti_i      (cti),
    .wb_bte_i      (bte),
    .wb_dat_o      (dat_r),
    .wb_ack_o      (ack),
    .wb_err_o      (err),
    .wb_rty_o      (rty),
    .ctrl_regs_o   (ctrl_regs),
    .status_regs_i (status_regs),
    .irq_src_i     (irq_src),
    .interrupt     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one request, samples 1 ns after the
  // response edge, then idles one cycle so the next request is not blocked.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic o_ack, output logic o_err,
                      output logic [31:0] o_dat, output logic o_irq);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    @(posedge clk); #1;
    o_ack = ack; o_err = err; o_dat = dat_r; o_irq = irq;
    $display("xfer we=%0d adr=%h wdat=%h sel=%h -> ack=%0d err=%0d rdat=%h irq=%0d",
             w, a, d, s, o_ack, o_err, o_dat, o_irq);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'b000; bte = 2'b00; irq_src = '0;
    status_regs = {32'h1234_5678, 32'hA5A5_0001};
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_0001, 32'h1234_5678, 32'h0, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ack", {31'b0, ack}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_rty", {31'b0, rty}, 32'h0);
    chk("reset_dat", dat_r, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_ctrl", {31'b0, |ctrl_regs}, 32'h0);

    // Read every mapped word after reset.
    for (int w = 0; w < 8; w++) begin
      xfer(1'b0, 8'(w * 4), 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
      chk($sformatf("rd%0d_ack", w), {31'b0, g_ack}, 32'h1);
      chk($sformatf("rd%0d_err", w), {31'b0, g_err}, 32'h0);
      chk($sformatf("rd%0d_dat", w), g_dat, exp_rd[w]);
    end

    // Byte-merged CTRL1 writes.
    xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("ctrl1_w1_ack", {31'b0, g_ack}, 32'h1);
    chk("ctrl1_w1_out", ctrl_regs[63:32], 32'hDEAD_BEEF);
    xfer(1'b1, 8'h04, 32'h0000_0011, 4'h1, g_ack, g_err, g_dat, g_irq);
    chk("ctrl1_w2_ack", {31'b0, g_ack}, 32'h1);
    chk("ctrl1_w2_out", ctrl_regs[63:32], 32'hDEAD_BE11);
    xfer(1'b0, 8'h04, 32'h0, 4'h0, g_ack, g_err, g_dat, g_irq);
    chk("ctrl1_rd", g_dat, 32'hDEAD_BE11);
    xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 4'h0, g_ack, g_err, g_dat, g_irq);
    chk("sel0_ack", {31'b0, g_ack}, 32'h1);
    chk("sel0_ctrl0", ctrl_regs[31:0], 32'h0);

    // Error responses: STAT write and unmapped read.
    xfer(1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("stat_wr_err", {31'b0, g_err}, 32'h1);
    chk("stat_wr_ack", {31'b0, g_ack}, 32'h0);
    chk("stat_wr_dat", g_dat, 32'hDEAD_BE11);
    chk("stat_wr_err_drop", {31'b0, err}, 32'h0);
    xfer(1'b0, 8'h20, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("unmap_err", {31'b0, g_err}, 32'h1);
    chk("unmap_ack", {31'b0, g_ack}, 32'h0);
    chk("unmap_dat", g_dat, 32'hDEAD_BE11);
    chk("unmap_rty", {31'b0, rty}, 32'h0);
    chk("err_ctrl_lo", ctrl_regs[63:0] == 64'hDEAD_BE11_0000_0000 ? 32'h1 : 32'h0, 32'h1);
    chk("err_ctrl_hi", {31'b0, |ctrl_regs[127:64]}, 32'h0);
    xfer(1'b0, 8'h10, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("stat0_rd", g_dat, 32'hA5A5_0001);

    // Interrupts: enable 0x05, pulse sources 0 and 1.
    xfer(1'b1, 8'h1C, 32'h0000_0005, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("en_ack", {31'b0, g_ack}, 32'h1);
    irq_src = 8'h03;
    @(posedge clk); #1;
    chk("irq_edge1", {31'b0, irq}, 32'h0);
    @(negedge clk);
    irq_src = 8'h00;
    @(posedge clk); #1;
    chk("irq_edge2", {31'b0, irq}, 32'h1);
    @(negedge clk);
    xfer(1'b0, 8'h18, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("pend_rd1", g_dat, 32'h0000_0003);
    xfer(1'b1, 8'h18, 32'h0000_0001, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("w1c_irq_resp_edge", {31'b0, g_irq}, 32'h1);
    chk("w1c_irq_after", {31'b0, irq}, 32'h0);
    xfer(1'b0, 8'h18, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("pend_rd2", g_dat, 32'h0000_0002);

    // Rise of source 2 coincides with a W1C of bit 2: set wins.
    irq_src = 8'h04;
    xfer(1'b1, 8'h18, 32'h0000_0004, 4'hF, g_ack, g_err, g_dat, g_irq);
    xfer(1'b0, 8'h18, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("pend_set_wins", g_dat, 32'h0000_0006);
    chk("pend_set_irq", {31'b0, g_irq}, 32'h1);
    // Source held high: clearing again sticks.
    xfer(1'b1, 8'h18, 32'h0000_0004, 4'hF, g_ack, g_err, g_dat, g_irq);
    xfer(1'b0, 8'h18, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("pend_held_clr", g_dat, 32'h0000_0002);
    chk("pend_held_irq", {31'b0, g_irq}, 32'h0);

    // Asynchronous reset between request and response edge.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h08; dat_w = 32'hCAFE_F00D; sel = 4'hF;
    #2;
    rst = 1'b1;
    irq_src = 8'h00;
    #1;
    chk("arst_ack", {31'b0, ack}, 32'h0);
    chk("arst_err", {31'b0, err}, 32'h0);
    chk("arst_dat", dat_r, 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_ctrl", {31'b0, |ctrl_regs}, 32'h0);
    @(posedge clk); #1;
    chk("arst_no_ack", {31'b0, ack}, 32'h0);
    chk("arst_ctrl2", ctrl_regs[95:64], 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    xfer(1'b0, 8'h18, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("post_rst_pend", g_dat, 32'h0);
    xfer(1'b0, 8'h1C, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("post_rst_en", g_dat, 32'h0);
    xfer(1'b1, 8'h08, 32'hCAFE_F00D, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("post_rst_wr_ack", {31'b0, g_ack}, 32'h1);
    chk("post_rst_ctrl2", ctrl_regs[95:64], 32'hCAFE_F00D);
    xfer(1'b0, 8'h08, 32'h0, 4'hF, g_ack, g_err, g_dat, g_irq);
    chk("post_rst_rd", g_dat, 32'hCAFE_F00D);
    chk("final_rty", {31'b0, rty}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dsp_slave_regfile.md
Name: wb_dsp_slave_regfile

Overview:
Parametrised Wishbone classic slave register file for the DSP block. It is the generalised successor to the fixed three-register slave. It provides:
- NUM_CTRL byte-writable control registers.
- NUM_STAT read-only status inputs.
- A latched, maskable interrupt controller with write-1-to-clear pending bits.
- Error responses for illegal accesses.

It sits between the Wishbone bus and the DSP engine core.

Parameters:
DW, 32, data width; a multiple of 8.
AW, 8, byte address width.
NUM_CTRL, 4, number of RW control registers (at least 1).
NUM_STAT, 2, number of RO status registers (at least 1).
NUM_IRQ, 8, number of interrupt sources (1..DW).
Legality: NUM_CTRL+NUM_STAT+2 <= 2^(AW-2).

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset, asynchronous, active-high
wb_adr_i  in  AW  byte address; word index = wb_adr_i[AW-1:2]
wb_dat_i  in  DW  write data
wb_sel_i  in  DW/8  byte enables
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  ignored (classic cycles only)
wb_bte_i  in  2  ignored
wb_dat_o  out  DW  read data, registered
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  error acknowledge
wb_rty_o  out  1  tied 0
ctrl_regs_o  out  NUM_CTRL*DW  control registers, reg i at [i*DW +: DW]
status_regs_i  in  NUM_STAT*DW  status inputs, same packing
irq_src_i  in  NUM_IRQ  interrupt sources, level signals from the DSP core
interrupt  out  1  registered interrupt request

Behaviour:
Clock and reset:
- One clock, wb_clk.
- wb_rst is asynchronous and active-high. Asserting it at any time, including mid-transfer, immediately clears wb_dat_o, wb_ack_o, wb_err_o, ctrl_regs_o, IRQ_PEND, IRQ_EN, the irq edge history and interrupt; all go to 0.
- An in-flight transfer is dropped. The master must re-issue it.

Word map (word index W):
- 0..NUM_CTRL-1: CTRL[W], RW.
- NUM_CTRL..NUM_CTRL+NUM_STAT-1: STAT, RO, live sample of status_regs_i.
- NUM_CTRL+NUM_STAT: IRQ_PEND, W1C, bits [NUM_IRQ-1:0]; upper bits read 0.
- NUM_CTRL+NUM_STAT+1: IRQ_EN, RW, bits [NUM_IRQ-1:0]; upper bits read 0.
- Above that: unmapped.
- wb_adr_i[1:0] is ignored.

Handshake:
- A request is wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o.
- On the edge where a request is seen, exactly one of wb_ack_o or wb_err_o goes high for one cycle, then drops. Latency is 1 cycle.
- A held stb produces one response every 2 cycles; there is no back-to-back ack.

Errors:
- wb_err_o is raised, instead of ack, for any access to an unmapped index and for a write to a STAT index.
- An errored access has no side effects. wb_dat_o is unchanged on an error.

Writes:
- Commit on the response edge, per byte lane where wb_sel_i[b]=1.
- CTRL and IRQ_EN are byte-merged; unselected bytes are preserved.
- IRQ_PEND: pending bits are cleared where the written bit is 1 and its byte lane is selected.
- A write with wb_sel_i=0 is acked with no change.

Reads:
- wb_dat_o is loaded with the addressed register on the response edge.
- wb_sel_i is ignored on reads.
- wb_dat_o holds its value otherwise.

Interrupts:
- irq_prev registers irq_src_i every cycle.
- A rise is irq_src_i & ~irq_prev. A rise sets the corresponding pending bit on that edge.
- If a set and a W1C clear of the same bit coincide, the set wins and the bit stays 1.
- interrupt <= |(IRQ_PEND & IRQ_EN), registered. It asserts 2 edges after the source rise is sampled, and deasserts 1 edge after pending or enable clears.
- A source held high does not re-set a pending bit after it has been cleared; a new rise is required.

Test Plan:
- Reset, then read all mapped words -> each read acked after 1 cycle; CTRL, IRQ_PEND and IRQ_EN read 0; STAT reads equal status_regs_i (drive 0xA5A5_0001 on STAT0).
- Write 0xDEADBEEF to CTRL1 with sel=4'b1111, then write 0x00000011 with sel=4'b0001, then read -> 0xDEADBE11; ctrl_regs_o[63:32] matches after each write's ack edge.
- Write to the STAT0 index and read unmapped index NUM_CTRL+NUM_STAT+2 -> wb_err_o pulses 1 cycle, wb_ack_o stays 0, no register changes, wb_rty_o stays 0 throughout.
- Set IRQ_EN=0x05, then pulse irq_src_i[0] and irq_src_i[1] -> IRQ_PEND=0x03; interrupt=1 two edges after the bit-0 rise. Write 0x01 to IRQ_PEND -> interrupt deasserts; IRQ_PEND reads 0x02.
- Rise irq_src_i[2] on the same edge as a W1C write of 0x04 -> IRQ_PEND[2] stays 1. Hold the source high, clear again -> the bit stays 0.
- Assert wb_rst asynchronously mid-write, between the request and the ack edge -> ack never appears, the target CTRL stays 0, all outputs are 0 immediately; a later clean transfer completes normally.
